// File: rtl/rv_mem_port_arbiter.sv
// rv_mem_port_arbiter
//   Shares one single-ported memory interface between the RV32I fetch port
//   and data port. Data wins ties; a starvation guard forces a fetch grant
//   after STARVE_MAX back-to-back data grants with fetch pending. A watchdog
//   forces an error completion after TIMEOUT busy cycles without mem_ack.
//   Optional feature macro: ARB_PERF_CNT_EN (adds grant/stall counters).
module rv_mem_port_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    // fetch port
    input  logic             if_req,
    input  logic [XLEN-1:0]  if_addr,
    output logic             if_ack,
    output logic             if_err,
    output logic [XLEN-1:0]  if_rdata,
    // data port
    input  logic             dm_req,
    input  logic [XLEN-1:0]  dm_addr,
    input  logic             dm_we,
    input  logic [2:0]       dm_size,
    input  logic [XLEN-1:0]  dm_wdata,
    output logic             dm_ack,
    output logic             dm_err,
    output logic [XLEN-1:0]  dm_rdata,
    // shared memory side
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    output logic             mem_we,
    output logic [2:0]       mem_size,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_ack,
    input  logic             mem_err,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             grant_dm
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_if_cnt,
    output logic [CNT_W-1:0] perf_dm_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  FETCH_SIZE = 3'b010;

    // Elaboration-time parameter sanity checks
    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_BUSY_IF = 2'b01,
        S_BUSY_DM = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [SC_W-1:0]   r_starve_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;

    logic              r_mem_req;
    logic [XLEN-1:0]   r_mem_addr;
    logic              r_mem_we;
    logic [2:0]        r_mem_size;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              r_grant_dm;

    logic              w_if_starved;
    logic              w_grant_if;
    logic              w_grant_dm;
    logic              w_done;
    logic              w_timeout;

    // Fetch has waited through STARVE_MAX data grants and must win now
    assign w_if_starved = if_req && (r_starve_cnt >= SC_W'(STARVE_MAX));

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, completion detection and owner ack/err/rdata routing
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        if_ack      = 1'b0;
        if_err      = 1'b0;
        if_rdata    = '0;
        dm_ack      = 1'b0;
        dm_err      = 1'b0;
        dm_rdata    = '0;

        case (r_state)
            S_IDLE: begin
                if (dm_req && !w_if_starved) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = S_BUSY_DM;
                end else if (if_req) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = S_BUSY_IF;
                end
            end
            S_BUSY_IF: begin
                w_timeout = !mem_ack && (r_tmo_cnt == TMO_W'(TIMEOUT));
                w_done    = mem_ack || w_timeout;
                if_ack    = w_done;
                if_err    = mem_ack ? mem_err : w_timeout;
                if_rdata  = mem_ack ? mem_rdata : '0;
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY_DM: begin
                w_timeout = !mem_ack && (r_tmo_cnt == TMO_W'(TIMEOUT));
                w_done    = mem_ack || w_timeout;
                dm_ack    = w_done;
                dm_err    = mem_ack ? mem_err : w_timeout;
                dm_rdata  = mem_ack ? mem_rdata : '0;
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the winner's request fields; hold them stable while busy
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= 3'b000;
            r_mem_wdata <= '0;
            r_grant_dm  <= 1'b0;
        end else if (w_grant_dm) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= dm_addr;
            r_mem_we    <= dm_we;
            r_mem_size  <= dm_size;
            r_mem_wdata <= dm_wdata;
            r_grant_dm  <= 1'b1;
        end else if (w_grant_if) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= if_addr;
            r_mem_we    <= 1'b0;
            r_mem_size  <= FETCH_SIZE;
            r_mem_wdata <= '0;
            r_grant_dm  <= 1'b0;
        end else if (w_done) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Watchdog: counts busy cycles, cleared on completion and in idle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != S_IDLE) && !w_done) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Starvation guard: saturating count of data grants taken over a waiting fetch
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_starve_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_if || !if_req) begin
                r_starve_cnt <= '0;
            end else if (w_grant_dm && (r_starve_cnt < SC_W'(STARVE_MAX))) begin
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_size  = r_mem_size;
    assign mem_wdata = r_mem_wdata;
    assign grant_dm  = r_grant_dm;

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_if_cnt;
    logic [CNT_W-1:0] r_perf_dm_cnt;
    logic [CNT_W-1:0] r_perf_stall_cnt;
    logic             w_stall;

    // A request is stalled in any cycle where its port does not own the bus
    assign w_stall = (if_req && (r_state != S_BUSY_IF)) ||
                     (dm_req && (r_state != S_BUSY_DM));

    // Free-running, wrapping grant and stall counters
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_perf_if_cnt    <= '0;
            r_perf_dm_cnt    <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_grant_if) begin
                r_perf_if_cnt <= r_perf_if_cnt + CNT_W'(1);
            end
            if (w_grant_dm) begin
                r_perf_dm_cnt <= r_perf_dm_cnt + CNT_W'(1);
            end
            if (w_stall) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_if_cnt    = r_perf_if_cnt;
    assign perf_dm_cnt    = r_perf_dm_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule
